// File: rtl/mult_share_arbiter_pkg.sv
// mult_share_arbiter_pkg: FSM state encoding and width helper shared by the arbiter files
package mult_share_arbiter_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, BUSY, RESP, ABORT} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/mult_share_arbiter_rr_pick.sv
// mult_share_arbiter_rr_pick: combinational round-robin picker, first request at or after ptr
module mult_share_arbiter_rr_pick #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          valid
);
  logic [N-1:0] rot;
  logic [IW:0]  sum;
  always_comb begin
    idx = '0;
    sum = '0;
    valid = |req;
    rot = N'({req, req} >> ptr);
    for (int k = N - 1; k >= 0; k--)
      if (rot[k]) begin
        sum = {1'b0, ptr} + (IW + 1)'(k);
        idx = sum >= (IW + 1)'(N) ? IW'(sum - (IW + 1)'(N)) : IW'(sum);
      end
  end
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one start/done multiplier datapath with timeout abort
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DATA_W = 16,
  parameter int RES_W = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] opa,
  input  logic [N_REQ*DATA_W-1:0] opb,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [RES_W-1:0]        rsp_data,
  output logic                    err,
  output logic [clog2(N_REQ)-1:0] err_id,
  output logic                    dp_start,
  output logic [DATA_W-1:0]       dp_a,
  output logic [DATA_W-1:0]       dp_b,
  input  logic                    dp_done,
  input  logic [RES_W-1:0]        dp_result,
  output logic                    busy
);
  localparam int IW = clog2(N_REQ);
  localparam int CW = clog2(TIMEOUT + 1);
  state_t state, nxt;
  logic [IW-1:0] ptr, win, pick;
  logic pick_v;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] a_arr [N_REQ];
  logic [DATA_W-1:0] b_arr [N_REQ];
  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign a_arr[i] = opa[i*DATA_W +: DATA_W];
    assign b_arr[i] = opb[i*DATA_W +: DATA_W];
  end
  mult_share_arbiter_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req(req), .ptr(ptr), .idx(pick), .valid(pick_v)
  );
  always_comb begin
    nxt = state == IDLE   ? (pick_v ? LAUNCH : IDLE) :
          state == LAUNCH ? BUSY :
          state == BUSY   ? (dp_done ? RESP : cnt == CW'(TIMEOUT) ? ABORT : BUSY) :
          IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr <= '0;
      win <= '0;
      gnt <= '0;
      cnt <= '0;
      dp_a <= '0;
      dp_b <= '0;
      rsp_data <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && pick_v) begin
        gnt <= N_REQ'(1) << pick;
        win <= pick;
        dp_a <= a_arr[pick];
        dp_b <= b_arr[pick];
        ptr <= pick == IW'(N_REQ - 1) ? '0 : pick + 1'b1;
      end
      if (state == LAUNCH) cnt <= '0;
      else if (state == BUSY && cnt != CW'(TIMEOUT)) cnt <= cnt + 1'b1;
      if (state == BUSY && dp_done) rsp_data <= dp_result;
      if (state == RESP || state == ABORT) gnt <= '0;
    end
  end
  assign dp_start  = state == LAUNCH;
  assign rsp_valid = state == RESP ? gnt : '0;
  assign err       = state == ABORT;
  assign err_id    = state == ABORT ? win : '0;
  assign busy      = state != IDLE;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed vector table plus multi-cycle corner sequences
module tb_mult_share_arbiter;
  localparam int N = 4, DW = 16, RW = 16, TO = 15;
  logic clk = 0, rst = 0;
  logic [N-1:0] req = '0;
  logic [N*DW-1:0] opa = '0, opb = '0;
  logic [N-1:0] gnt, rsp_valid;
  logic [RW-1:0] rsp_data, dp_result;
  logic err, dp_start, dp_done, busy;
  logic [1:0] err_id;
  logic [DW-1:0] dp_a, dp_b;
  int pass_cnt = 0, total = 0, multi = 0;
  int dp_delay = 10, mcnt = 0;
  bit hang = 0, stray = 0, md = 0;
  logic [RW-1:0] mres = '0;

  always #5 clk = ~clk;

  mult_share_arbiter #(.N_REQ(N), .DATA_W(DW), .RES_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .opa(opa), .opb(opb), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err), .err_id(err_id),
    .dp_start(dp_start), .dp_a(dp_a), .dp_b(dp_b), .dp_done(dp_done),
    .dp_result(dp_result), .busy(busy)
  );

  // datapath model: done pulses dp_delay cycles after the start cycle, product truncated
  assign dp_done = md | stray;
  assign dp_result = mres;
  always @(negedge clk) begin
    if (mcnt > 0) begin
      mcnt--;
      md = (mcnt == 0) && !hang;
    end else md = 0;
    if (dp_start) begin
      mcnt = dp_delay;
      mres = RW'(dp_a * dp_b);
    end
  end

  always @(negedge clk) if ($countones(gnt) > 1) multi++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic wait_rsp(input int lim, output int n);
    n = 0;
    while (rsp_valid == '0 && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask

  typedef struct {
    logic [3:0] req;
    logic [63:0] a, b;
    logic [3:0] gnt;
    logic [15:0] da, res;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, e, b, p;
    logic [15:0] pd;
    logic [3:0] pv;
    logic [15:0] rr_res[4];
    tbl[0] = '{4'b0001, 64'h0000_0000_0000_00C8, 64'h0000_0000_0000_0032, 4'b0001, 16'h00C8, 16'h2710};
    tbl[1] = '{4'b0010, 64'h0000_0000_0010_0000, 64'h0000_0000_0020_0000, 4'b0010, 16'h0010, 16'h0200};
    tbl[2] = '{4'b0100, 64'h0000_0100_0000_0000, 64'h0000_0100_0000_0000, 4'b0100, 16'h0100, 16'h0000};
    tbl[3] = '{4'b1000, 64'hFFFF_0000_0000_0000, 64'h0002_0000_0000_0000, 4'b1000, 16'hFFFF, 16'hFFFE};
    tbl[4] = '{4'b1001, 64'h0003_0000_0000_0007, 64'h0005_0000_0000_0009, 4'b0001, 16'h0007, 16'h003F};
    tbl[5] = '{4'b1001, 64'h0003_0000_0000_0007, 64'h0005_0000_0000_0009, 4'b1000, 16'h0003, 16'h000F};
    tbl[6] = '{4'b0101, 64'h0000_0011_0000_0002, 64'h0000_0011_0000_0003, 4'b0001, 16'h0002, 16'h0006};
    tbl[7] = '{4'b0101, 64'h0000_0011_0000_0002, 64'h0000_0011_0000_0003, 4'b0100, 16'h0011, 16'h0121};
    rr_res = '{16'h0010, 16'h0040, 16'h0090, 16'h0100};

    repeat (2) @(negedge clk);
    chk("reset_gnt", gnt, 0);
    chk("reset_busy", {busy, err, dp_start, rsp_valid}, 0);
    chk("reset_regs", {dp_a, dp_b, rsp_data}, 0);
    rst = 1;
    @(negedge clk);

    stray = 1;
    @(negedge clk);
    stray = 0;
    chk("idle_stray", {busy, rsp_valid}, 0);

    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req; opa = tbl[i].a; opb = tbl[i].b;
      @(negedge clk);
      chk("tbl_gnt", gnt, tbl[i].gnt);
      chk("tbl_start", dp_start, 1);
      chk("tbl_dp_a", dp_a, tbl[i].da);
      wait_rsp(30, n);
      chk("tbl_latency", n, 11);
      chk("tbl_rsp_valid", rsp_valid, tbl[i].gnt);
      chk("tbl_rsp_data", rsp_data, tbl[i].res);
      req = '0;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("rsp_data_held", rsp_data, 16'h0121);

    req = 4'b0001; opa = 64'h5; opb = 64'h6;
    @(negedge clk);
    stray = 1;
    @(negedge clk);
    stray = 0;
    chk("launch_stray_busy", busy, 1);
    chk("launch_stray_rsp", rsp_valid, 0);
    wait_rsp(30, n);
    chk("launch_stray_lat", n, 10);
    chk("launch_stray_data", rsp_data, 16'h001E);
    req = '0;
    @(negedge clk);

    dp_delay = 16;
    req = 4'b0010; opa = 64'h0003_0000; opb = 64'h0004_0000;
    @(negedge clk);
    n = 0; e = 0;
    while (rsp_valid == '0 && n < 30) begin
      @(negedge clk);
      n++;
      if (err) e++;
    end
    chk("tie_latency", n, 17);
    chk("tie_no_err", e, 0);
    chk("tie_data", rsp_data, 16'h000C);
    req = '0; dp_delay = 10;
    @(negedge clk);

    hang = 1;
    req = 4'b0100;
    @(negedge clk);
    chk("to_start", dp_start, 1);
    n = 0;
    while (!err && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("to_latency", n, 17);
    chk("to_err_id", err_id, 2);
    chk("to_no_rsp", rsp_valid, 0);
    chk("to_data_kept", rsp_data, 16'h000C);
    req = '0;
    @(negedge clk);
    chk("to_after", {busy, err, gnt}, 0);
    hang = 0;
    req = 4'b1000; opa = 64'h0002_0000_0000_0000; opb = 64'h0008_0000_0000_0000;
    @(negedge clk);
    chk("to_next_gnt", gnt, 4'b1000);
    wait_rsp(30, n);
    chk("to_next_data", rsp_data, 16'h0010);
    req = '0;
    @(negedge clk);

    dp_delay = 15;
    req = 4'b0010; opa = 64'h0001_0000; opb = 64'h0001_0000;
    @(negedge clk);
    repeat (9) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_mid_outs", {gnt, busy, dp_a, rsp_valid}, 0);
    @(negedge clk);
    rst = 1; req = '0; dp_delay = 10;
    b = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (busy || rsp_valid != 0 || err) b++;
    end
    chk("stale_done_ignored", b, 0);
    req = 4'b1001; opa = 64'h4; opb = 64'h5;
    @(negedge clk);
    chk("rst_ptr_gnt", gnt, 4'b0001);
    wait_rsp(30, n);
    chk("rst_next_data", rsp_data, 16'h0014);
    req = '0;
    @(negedge clk);

    rst = 0;
    @(negedge clk);
    rst = 1;
    req = 4'b1111; opa = 64'h0004_0003_0002_0001; opb = 64'h0040_0030_0020_0010;
    for (int j = 0; j < 5; j++) begin
      n = 0;
      while (gnt == '0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("rr_gnt", gnt, 4'b0001 << (j % 4));
      wait_rsp(30, n);
      chk("rr_data", rsp_data, rr_res[j % 4]);
      @(negedge clk);
      chk("rr_bubble", busy, 0);
    end
    req = '0;
    @(negedge clk);

    req = 4'b0100; opa = 64'h0000_0007_0000_0000; opb = 64'h0000_0006_0000_0000;
    @(negedge clk);
    chk("stab_gnt", gnt, 4'b0100);
    opa = 64'h0000_0009_0000_0000; req = '0;
    @(negedge clk);
    chk("stab_dp_a", dp_a, 16'h0007);
    p = 0; pd = '0; pv = '0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (rsp_valid != 0) begin
        p++;
        pd = rsp_data;
        pv = rsp_valid;
      end
    end
    chk("stab_pulses", p, 1);
    chk("stab_rsp_valid", pv, 4'b0100);
    chk("stab_data", pd, 16'h002A);

    chk("gnt_onehot", multi, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
